cpu6_mtimer: RTL and testbench
==============================

Name: cpu6_mtimer

Overview:
- Memory-mapped machine timer; responder on the cpu6 core data bus (memwriteM/dataaddr/writedata/readdata).
- Generates the core's tmr_irq_r input.
- Holds a 64-bit mtime counter with a programmable prescaler and a 64-bit mtimecmp register.
- Sits beside data RAM; the top-level readdata mux selects it on hit.

Parameters:
- BASE, 32'h0200_0000, byte base address of the 32-byte register window; BASE[4:0] must be 0.
- PRESCALE_RST, 32'd0, reset value of the prescale register (0 = increment every clk).
- EN_RST, 1'b0, reset value of ctrl.en.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memwriteM  in  1  core store strobe; write occurs at the rising edge while high.
- dataaddr  in  32  core byte address.
- writedata  in  32  core store data.
- readdata  out  32  register read data; combinational from dataaddr; 0 when not hit.
- hit  out  1  combinational; dataaddr[31:5] == BASE[31:5].
- tmr_irq_r  out  1  registered timer interrupt, level.

Behaviour:
- Address decode:
  - hit uses dataaddr[31:5]; register select uses dataaddr[4:2]; dataaddr[1:0] is ignored.
  - Only full-word access is supported.
- Register map (offset, name, access):
  - 0x00 mtime_lo RW
  - 0x04 mtime_hi RW
  - 0x08 mtimecmp_lo RW
  - 0x0C mtimecmp_hi RW
  - 0x10 ctrl: bit0 en RW; bit1 pending RO, which is the current value of tmr_irq_r; other bits read 0.
  - 0x14 prescale RW
  - 0x18, 0x1C: read 0, writes ignored.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; en = EN_RST; prescale = PRESCALE_RST; prescale counter pcnt = 0; tmr_irq_r = 0.
  - readdata and hit follow the inputs combinationally; no reset is needed.
- Reads: zero latency, because the core has no read strobe. Reads have no side effects.
- Writes: take effect only when memwriteM & hit, at the rising edge.
- Tick generation:
  - If en = 1: if pcnt == prescale then tick = 1 and pcnt <= 0, else pcnt <= pcnt + 1.
  - If en = 0: pcnt holds and tick = 0.
- mtime update:
  - On tick, mtime <= mtime + 1 as a 64-bit add with carry lo->hi.
  - Wraps from 2^64-1 to 0.
- Simultaneous events:
  - A write to mtime_lo or mtime_hi in a tick cycle: the written half takes writedata, the other half holds, and the increment is dropped for that cycle.
  - pcnt still advances/clears normally in that cycle.
- Writing prescale also clears pcnt to 0 in the same edge.
- Clearing en freezes both mtime and pcnt. Setting en resumes from the held pcnt.
- Interrupt:
  - tmr_irq_r <= (mtime >= mtimecmp), using an unsigned 64-bit compare on the registered values.
  - Effective latency is one cycle after a register update. Example: a write to mtimecmp at edge N gives the new irq level at edge N+1.
  - Interrupt generation is independent of en, so a frozen timer that is already past mtimecmp keeps irq high.
  - Level-only: software clears it by raising mtimecmp.
- Reset mid-operation: all state returns to reset values at that edge; an in-flight write in the reset cycle is discarded.
- 64-bit reads are not atomic. Software uses the hi/lo/hi re-read loop, and writes mtimecmp_hi = all-ones first to avoid a spurious irq.

Decomposition:
- Shared package/defines (defines.v): CPU6_MTIMER_OFF_* offset constants, CTRL bit indices, and the window size of 32 bytes.
- One natural sub-module, cpu6_mtimer_prescaler:
  - Inputs: en, prescale, clr.
  - Outputs: tick; holds pcnt.
- The 64-bit counter, compare, and bus decode stay in the top.
- Use cpu6_dfflr-style flops where practical.

Test Plan:
- Reset, read all offsets -> mtime 0/0, mtimecmp FFFF_FFFF/FFFF_FFFF, ctrl 0, prescale 0, 0x18 reads 0; tmr_irq_r = 0; hit = 0 for address BASE+0x20.
- Write prescale = 3, en = 1, idle 20 clk -> mtime_lo == 5 (ticks on cycles 4, 8, 12, 16, 20); with en = 0 for 10 clk, mtime_lo is unchanged.
- Write mtime_lo = FFFF_FFFF, mtime_hi = 0, prescale = 0, en = 1 -> next tick gives mtime_hi = 1, mtime_lo = 0; from mtime = all-ones, one tick wraps to 0/0.
- With mtime ≈ 100 running, write mtimecmp_hi = 0, then mtimecmp_lo = 110 -> tmr_irq_r rises exactly one clk after mtime reaches 110 and ctrl.pending reads 1; write mtimecmp_lo = FFFF_FFFF -> irq falls one clk after the write.
- Write mtime_lo = 50 in a tick cycle -> mtime_lo = 50 next cycle, no 51; memwriteM with dataaddr outside the window -> no register changes.
- Assert reset while en = 1 and irq = 1 -> all registers return to reset values at that edge; irq = 0 the following cycle.

Source files
------------

// File: rtl/cpu6_mtimer_pkg.sv
// Shared register-map constants and types for the cpu6 machine timer.
// Imported by the timer top and its prescaler.
package cpu6_mtimer_pkg;

    localparam int unsigned WIN_BYTES = 32;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PRESCALE    = 5'h14;
    localparam logic [4:0] OFF_RSVD0       = 5'h18;
    localparam logic [4:0] OFF_RSVD1       = 5'h1C;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_PEND = 1;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        pending;
        logic        en;
    } ctrl_t;

    function automatic logic [2:0] word_sel(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/cpu6_mtimer_prescaler.sv
// Prescale counter: emits one tick every (prescale + 1) enabled cycles.
// Holds its count while disabled; clr restarts the count from zero.
module cpu6_mtimer_prescaler
    import cpu6_mtimer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] prescale,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cpu6_mtimer.sv
// Memory-mapped 64-bit machine timer with prescaler and compare interrupt.
// Responds on the cpu6 data bus; reads are combinational and side-effect free.
module cpu6_mtimer
    import cpu6_mtimer_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h0200_0000,
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic        EN_RST       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        tmr_irq_r
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] prescale;
    logic        ctrl_en;
    logic        tick;
    logic [2:0]  sel;
    logic        we;
    logic [7:0]  wr_oh;
    ctrl_t       ctrl_rd;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^dataaddr[1:0];

    assign hit = (dataaddr[31:5] == BASE[31:5]);
    assign sel = dataaddr[4:2];
    assign we  = memwriteM && hit;

    always_comb begin
        wr_oh = '0;
        if (we) begin
            wr_oh[sel] = 1'b1;
        end
    end

    cpu6_mtimer_prescaler u_presc (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_en),
        .prescale (prescale),
        .clr      (wr_oh[word_sel(OFF_PRESCALE)]),
        .tick     (tick)
    );

    // A bus write to either half wins over the tick for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= '0;
        end else if (wr_oh[word_sel(OFF_MTIME_LO)]) begin
            mtime[31:0] <= writedata;
        end else if (wr_oh[word_sel(OFF_MTIME_HI)]) begin
            mtime[63:32] <= writedata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp <= '1;
        end else if (wr_oh[word_sel(OFF_MTIMECMP_LO)]) begin
            mtimecmp[31:0] <= writedata;
        end else if (wr_oh[word_sel(OFF_MTIMECMP_HI)]) begin
            mtimecmp[63:32] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en <= EN_RST;
        end else if (wr_oh[word_sel(OFF_CTRL)]) begin
            ctrl_en <= writedata[CTRL_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= PRESCALE_RST;
        end else if (wr_oh[word_sel(OFF_PRESCALE)]) begin
            prescale <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_irq_r <= 1'b0;
        end else begin
            tmr_irq_r <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        ctrl_rd         = '0;
        ctrl_rd.en      = ctrl_en;
        ctrl_rd.pending = tmr_irq_r;
    end

    always_comb begin
        readdata = '0;
        if (hit) begin
            unique case (1'b1)
                sel == word_sel(OFF_MTIME_LO):    readdata = mtime[31:0];
                sel == word_sel(OFF_MTIME_HI):    readdata = mtime[63:32];
                sel == word_sel(OFF_MTIMECMP_LO): readdata = mtimecmp[31:0];
                sel == word_sel(OFF_MTIMECMP_HI): readdata = mtimecmp[63:32];
                sel == word_sel(OFF_CTRL):        readdata = ctrl_rd;
                sel == word_sel(OFF_PRESCALE):    readdata = prescale;
                default:                          readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_mtimer.sv
// Directed bench for cpu6_mtimer: expected reads are queued, then drained
// against the bus in the low clock phase.
module tb_cpu6_mtimer;
    import cpu6_mtimer_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk;
    logic        reset;
    logic        memwriteM;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        tmr_irq_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_t;

    rd_t sb_q[$];

    cpu6_mtimer #(.BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwriteM (memwriteM),
        .dataaddr  (dataaddr),
        .writedata (writedata),
        .readdata  (readdata),
        .hit       (hit),
        .tmr_irq_r (tmr_irq_r)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
        end
    endtask

    task automatic exp_rd(input string tag, input logic [4:0] off,
                          input logic [31:0] e);
        rd_t it;
        it.tag  = tag;
        it.addr = BASE | {27'd0, off};
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        rd_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            dataaddr = it.addr;
            #1;
            chk(it.tag, readdata, it.exp);
        end
    endtask

    task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
        memwriteM = 1'b1;
        dataaddr  = a;
        writedata = d;
        @(negedge clk);
        memwriteM = 1'b0;
        dataaddr  = '0;
        writedata = '0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        wr_abs(BASE | {27'd0, off}, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        memwriteM = 1'b0;
        dataaddr  = '0;
        writedata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_irq", {31'd0, tmr_irq_r}, 32'd0);
        exp_rd("rst_mtime_lo", OFF_MTIME_LO, 32'h0);
        exp_rd("rst_mtime_hi", OFF_MTIME_HI, 32'h0);
        exp_rd("rst_cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
        exp_rd("rst_cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
        exp_rd("rst_ctrl", OFF_CTRL, 32'h0);
        exp_rd("rst_prescale", OFF_PRESCALE, 32'h0);
        exp_rd("rst_rsvd18", OFF_RSVD0, 32'h0);
        drain();
        dataaddr = BASE + 32'h20;
        #1;
        chk("hit_out", {31'd0, hit}, 32'd0);
        chk("rd_out", readdata, 32'd0);
        dataaddr = BASE + 32'h1C;
        #1;
        chk("hit_in", {31'd0, hit}, 32'd1);

        // prescale 3: ticks every 4th enabled cycle
        idle(1);
        wr(OFF_PRESCALE, 32'd3);
        wr(OFF_CTRL, 32'd1);
        idle(20);
        exp_rd("presc_lo", OFF_MTIME_LO, 32'd5);
        exp_rd("presc_ctrl", OFF_CTRL, 32'd1);
        drain();
        wr(OFF_CTRL, 32'd0);
        idle(10);
        exp_rd("frozen_lo", OFF_MTIME_LO, 32'd5);
        exp_rd("frozen_ctrl", OFF_CTRL, 32'd0);
        drain();

        // carry lo -> hi and 64-bit wrap
        wr(OFF_PRESCALE, 32'd0);
        wr(OFF_MTIME_HI, 32'd0);
        wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
        wr(OFF_CTRL, 32'd1);
        exp_rd("carry_pre_lo", OFF_MTIME_LO, 32'hFFFF_FFFF);
        drain();
        idle(1);
        exp_rd("carry_hi", OFF_MTIME_HI, 32'd1);
        exp_rd("carry_lo", OFF_MTIME_LO, 32'd0);
        drain();
        wr(OFF_CTRL, 32'd0);
        wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
        wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
        exp_rd("ones_hi", OFF_MTIME_HI, 32'hFFFF_FFFF);
        drain();
        wr(OFF_CTRL, 32'd1);
        idle(1);
        exp_rd("wrap_hi", OFF_MTIME_HI, 32'd0);
        exp_rd("wrap_lo", OFF_MTIME_LO, 32'd0);
        drain();
        wr(OFF_CTRL, 32'd0);

        // compare interrupt timing
        wr(OFF_MTIMECMP_HI, 32'd0);
        wr(OFF_MTIMECMP_LO, 32'd110);
        wr(OFF_MTIME_LO, 32'd100);
        wr(OFF_MTIME_HI, 32'd0);
        chk("cmp_pre_irq", {31'd0, tmr_irq_r}, 32'd0);
        wr(OFF_CTRL, 32'd1);
        idle(9);
        exp_rd("cmp_109", OFF_MTIME_LO, 32'd109);
        drain();
        chk("cmp_109_irq", {31'd0, tmr_irq_r}, 32'd0);
        idle(1);
        exp_rd("cmp_110", OFF_MTIME_LO, 32'd110);
        drain();
        chk("cmp_110_irq", {31'd0, tmr_irq_r}, 32'd0);
        idle(1);
        chk("cmp_irq_rise", {31'd0, tmr_irq_r}, 32'd1);
        exp_rd("cmp_pending", OFF_CTRL, 32'd3);
        drain();
        wr(OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
        chk("cmp_irq_hold", {31'd0, tmr_irq_r}, 32'd1);
        idle(1);
        chk("cmp_irq_fall", {31'd0, tmr_irq_r}, 32'd0);

        // write in a tick cycle wins; outside window ignored
        wr(OFF_MTIME_HI, 32'd0);
        wr(OFF_MTIME_LO, 32'd50);
        exp_rd("wtick_lo", OFF_MTIME_LO, 32'd50);
        drain();
        wr(OFF_CTRL, 32'd0);
        exp_rd("wtick_next", OFF_MTIME_LO, 32'd51);
        drain();
        wr_abs(BASE + 32'h20, 32'h0000_DEAD);
        wr_abs(BASE + 32'h40, 32'h0000_BEEF);
        wr(OFF_RSVD0, 32'h1234_5678);
        exp_rd("oow_lo", OFF_MTIME_LO, 32'd51);
        exp_rd("oow_hi", OFF_MTIME_HI, 32'd0);
        exp_rd("oow_rsvd", OFF_RSVD0, 32'd0);
        exp_rd("oow_prescale", OFF_PRESCALE, 32'd0);
        drain();

        // reset while running with irq high
        wr(OFF_MTIMECMP_LO, 32'd0);
        wr(OFF_CTRL, 32'd1);
        idle(1);
        chk("pre_rst_irq", {31'd0, tmr_irq_r}, 32'd1);
        reset     = 1'b1;
        memwriteM = 1'b1;
        dataaddr  = BASE | {27'd0, OFF_MTIMECMP_LO};
        writedata = 32'd5;
        @(negedge clk);
        reset     = 1'b0;
        memwriteM = 1'b0;
        chk("mid_rst_irq", {31'd0, tmr_irq_r}, 32'd0);
        exp_rd("mid_rst_lo", OFF_MTIME_LO, 32'd0);
        exp_rd("mid_rst_hi", OFF_MTIME_HI, 32'd0);
        exp_rd("mid_rst_cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
        exp_rd("mid_rst_cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
        exp_rd("mid_rst_ctrl", OFF_CTRL, 32'd0);
        exp_rd("mid_rst_presc", OFF_PRESCALE, 32'd0);
        drain();
        idle(1);
        chk("post_rst_irq", {31'd0, tmr_irq_r}, 32'd0);
        exp_rd("post_rst_lo", OFF_MTIME_LO, 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
